// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: shared state, defaults and store-entry type for the store monitor.
package store_monitor_pkg;
  typedef enum logic {RUN, DONE} state_t;
  localparam logic [31:0] DEF_DONE_ADDR  = 32'd100;
  localparam logic [31:0] DEF_PASS_VALUE = 32'd25;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;
endpackage

// File: rtl/store_monitor_sync_fifo.sv
// sync_fifo: show-ahead FIFO with a registered head word and wrap-bit pointers.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd, w_rd_nxt;
  logic [W-1:0] r_rdata;
  logic         w_nxt_empty;
  assign w_rd_nxt    = r_rd + {{AW{1'b0}}, pop};
  assign w_nxt_empty = (w_rd_nxt == r_wr) && !push;
  assign empty       = (r_wr == r_rd);
  assign full        = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign rdata       = r_rdata;
  always_ff @(posedge clk)
    if (push) r_mem[r_wr[AW-1:0]] <= wdata;
  // Head register tracks the next head; a push into the slot about to be head goes straight in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
    end else begin
      if (push) r_wr <= r_wr + (AW+1)'(1);
      r_rd <= w_rd_nxt;
      if (!w_nxt_empty)
        r_rdata <= (push && w_rd_nxt == r_wr) ? wdata : r_mem[w_rd_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/store_monitor.sv
// store_monitor: queues data-memory stores for draining and flags end-of-program pass/fail.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] DONE_ADDR  = DEF_DONE_ADDR,
  parameter logic [31:0] PASS_VALUE = DEF_PASS_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             done,
  output logic             pass,
  output logic             overflow,
  output logic [CNT_W-1:0] store_count
);
  state_t           r_state, w_state_nxt;
  logic             w_sample, w_fin, w_pop, w_push, w_full, w_empty;
  logic             r_pass, r_overflow;
  logic [CNT_W-1:0] r_count;
  entry_t           w_in, w_head;
  assign w_sample = MemWrite && (r_state == RUN);
  assign w_fin    = w_sample && (DataAdr == DONE_ADDR);
  assign w_pop    = !w_empty && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push   = w_sample && (!w_full || w_pop);
  assign w_in     = '{addr: DataAdr, data: WriteData};
  always_comb w_state_nxt = w_fin ? DONE : r_state;
  always_ff @(posedge clk)
    r_state <= reset ? RUN : w_state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pass     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_fin) r_pass <= (WriteData == PASS_VALUE);
      if (w_sample && !w_push) r_overflow <= 1'b1;
      if (w_sample && r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end
  sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_in),
    .full  (w_full),
    .empty (w_empty),
    .rdata (w_head)
  );
  assign out_valid   = !w_empty;
  assign out_addr    = w_head.addr;
  assign out_data    = w_head.data;
  assign done        = (r_state == DONE);
  assign pass        = r_pass;
  assign overflow    = r_overflow;
  assign store_count = r_count;
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed-vector bench for store_monitor.
module tb_store_monitor;
  logic        clk = 0;
  logic        reset = 1;
  logic        MemWrite = 0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        out_valid, out_ready = 0;
  logic [31:0] out_addr, out_data;
  logic        done, pass, overflow;
  logic [15:0] store_count;
  int n_tests = 0;
  int n_fail = 0;
  store_monitor dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .done(done), .pass(pass), .overflow(overflow), .store_count(store_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  logic [31:0] adr3 [3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] dat3 [3] = '{32'h11, 32'h22, 32'h33};
  initial begin
    tick(); tick();
    reset = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_flags", {61'd0, done, pass, overflow}, 64'd0);
    chk("rst_count", 64'(store_count), 64'd0);
    chk("rst_head", {out_addr, out_data}, 64'd0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      store(adr3[i], dat3[i]);
      chk("drain3_valid", 64'(out_valid), 64'd1);
      chk("drain3_head", {out_addr, out_data}, {adr3[i], dat3[i]});
    end
    chk("cnt3", 64'(store_count), 64'd3);
    chk("ovf3", 64'(overflow), 64'd0);
    store(32'd100, 32'd25);
    chk("done_pass", {62'd0, done, pass}, 64'd3);
    chk("done_head", {out_addr, out_data}, {32'd100, 32'd25});
    chk("done_cnt", 64'(store_count), 64'd4);
    store(32'd96, 32'd7);
    chk("ignored_valid", 64'(out_valid), 64'd0);
    chk("ignored_cnt", 64'(store_count), 64'd4);
    chk("ignored_pass", {62'd0, done, pass}, 64'd3);
    do_reset();
    store(32'd100, 32'd7);
    chk("fail_flags", {62'd0, done, pass}, 64'd2);
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 9; i++) store(32'h200 + 32'(4 * i), 32'(i));
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(store_count), 64'd9);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain_valid", 64'(out_valid), 64'd1);
      chk("ovf_drain_head", {out_addr, out_data}, {32'h200 + 32'(4 * i), 32'(i)});
      tick();
    end
    chk("ovf_empty", 64'(out_valid), 64'd0);
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 8; i++) store(32'h300 + 32'(4 * i), 32'(i));
    chk("full_hold", {out_addr, out_data}, {32'h304, 32'd1});
    out_ready = 1;
    store(32'h324, 32'd9);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    chk("fullpp_cnt", 64'(store_count), 64'd9);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpp_valid", 64'(out_valid), 64'd1);
      chk("fullpp_head", {out_addr, out_data}, {32'h300 + 32'(4 * i), 32'(i)});
      tick();
    end
    chk("fullpp_empty", 64'(out_valid), 64'd0);
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) store(adr3[i], dat3[i]);
    store(32'd100, 32'd25);
    chk("pre_rst_done", {62'd0, done, pass}, 64'd3);
    reset = 1; MemWrite = 1; DataAdr = 32'h50; WriteData = 32'h66;
    tick();
    reset = 0; MemWrite = 0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_flags", {61'd0, done, pass, overflow}, 64'd0);
    chk("mid_rst_cnt", 64'(store_count), 64'd0);
    store(32'h40, 32'h55);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_head", {out_addr, out_data}, {32'h40, 32'h55});
    chk("post_rst_cnt", 64'(store_count), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
